// File: rtl/wave_cap_pkg.sv
// Shared definitions for the waveform capture sequencer.
//   AW_DEF        default address width (buffer depth 2**AW_DEF samples)
//   AUTO_TMO_DEF  default auto-trigger timeout in samples
//   state_e       capture FSM state encoding
package wave_cap_pkg;

  localparam int AW_DEF       = 8;
  localparam int AUTO_TMO_DEF = 4095;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/wave_cap_addr_cnt.sv
// Circular-buffer write-address generator.
// A write request registers wr_en for one cycle together with the current
// pointer on wr_addr; the pointer then advances, wrapping at 2**AW.
// Ports:
//   clk, nrst   clock, asynchronous active-low reset
//   wr_req      accept one sample this cycle
//   wr_en       registered RAM write enable
//   wr_addr     registered RAM write address (address of the last write)
//   next_addr   address the next accepted sample will be written to
module wave_cap_addr_cnt #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          wr_req,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] next_addr
);

  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] ptr_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      ptr_q     <= '0;
    end else begin
      wr_en_q <= wr_req;
      if (wr_req) begin
        wr_addr_q <= ptr_q;
        ptr_q     <= ptr_q + 1'b1;  // natural wrap at 2**AW
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign next_addr = ptr_q;

endmodule

// File: rtl/wave_capture_ctrl.sv
// Capture sequencer: writes ADC samples into a circular buffer, keeps
// pre_len samples ahead of the trigger and fills the rest of the buffer
// after it, then reports the trigger-point address.
// Optional feature: define WAVE_CAP_AUTO_EN to force a trigger after
// AUTO_TMO samples in WAIT without a trigger edge (auto_trig flags it).
//
// state | meaning
// IDLE  | not armed, no writes
// PRE   | collecting pre_q pre-trigger samples, edges ignored
// WAIT  | writing samples, looking for a rising trigger edge
// POST  | writing the remaining DEPTH - pre_q samples
// DONE  | capture complete, waiting for the next arm
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   sample_en          ADC sample valid strobe
//   trig_in            trigger level
//   arm / abort        start capture / return to IDLE (abort wins)
//   pre_len            pre-trigger depth, captured on arm
//   wr_en / wr_addr    registered RAM write port
//   trig_addr          address of the first post-trigger sample
//   busy / done        capture running / capture finished
//   auto_trig          last capture was forced by timeout
module wave_capture_ctrl
  import wave_cap_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int AUTO_TMO = AUTO_TMO_DEF
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          sample_en,
  input  logic          trig_in,
  input  logic          arm,
  input  logic          abort,
  input  logic [AW-1:0] pre_len,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] trig_addr,
  output logic          busy,
  output logic          done,
  output logic          auto_trig
);

  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

  if (AUTO_TMO < 1) begin : g_tmo_chk
    $error("AUTO_TMO must be at least 1");
  end

  state_e        state_q;
  logic [AW-1:0] pre_q;
  logic [AW:0]   cnt_q;
  logic          trig_d_q;
  logic [AW-1:0] trig_addr_q;
  logic          busy_q;
  logic          done_q;

  logic          active;
  logic          wr_req;
  logic          edge_ev;
  logic          fire;
  logic [AW:0]   cnt_inc;
  logic [AW:0]   post_len;
  logic [AW-1:0] next_addr;

  assign active   = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
  assign wr_req   = sample_en && !abort && active;
  assign edge_ev  = sample_en && trig_in && !trig_d_q;
  assign cnt_inc  = cnt_q + ONE_C;
  assign post_len = DEPTH_C - {1'b0, pre_q};

`ifdef WAVE_CAP_AUTO_EN
  localparam int TW = $clog2(AUTO_TMO + 1);
  logic [TW-1:0] tmo_q;
  logic          auto_q;
  assign fire      = edge_ev || (sample_en && (tmo_q == TW'(AUTO_TMO)));
  assign auto_trig = auto_q;
`else
  assign fire      = edge_ev;
  assign auto_trig = 1'b0;
`endif

  wave_cap_addr_cnt #(.AW(AW)) u_addr_cnt (
    .clk       (clk),
    .nrst      (nrst),
    .wr_req    (wr_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      trig_d_q    <= 1'b0;
      trig_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef WAVE_CAP_AUTO_EN
      tmo_q       <= '0;
      auto_q      <= 1'b0;
`endif
    end else if (abort) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (sample_en) trig_d_q <= trig_in;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // busy/done change one cycle after entering DONE so done follows the final wr_en
          if (state_q == ST_DONE && busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          if (arm) begin
            pre_q    <= pre_len;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            trig_d_q <= trig_in;  // a level already high at arm is not an edge
            state_q  <= (pre_len == '0) ? ST_WAIT : ST_PRE;
`ifdef WAVE_CAP_AUTO_EN
            tmo_q    <= '0;
            auto_q   <= 1'b0;
`endif
          end
        end
        ST_PRE: begin
          if (sample_en) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == {1'b0, pre_q}) state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fire) begin
            trig_addr_q <= next_addr;
            cnt_q       <= ONE_C;
            // with pre_q = DEPTH-1 the trigger sample is the only post sample
            state_q     <= (post_len == ONE_C) ? ST_DONE : ST_POST;
`ifdef WAVE_CAP_AUTO_EN
            auto_q      <= !edge_ev;
          end else if (sample_en) begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        ST_POST: begin
          if (sample_en) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == post_len) state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign trig_addr = trig_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
